// File: rtl/tdm_demux.sv
// rtl/tdm_demux.sv - TDM receive demux: locks to slot-0 sync, steers words to per-channel registers.
module tdm_demux #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          din,
    input  logic                      din_valid,
    input  logic                      sync,
    output logic [CHANNELS*WIDTH-1:0] dout,
    output logic [CHANNELS-1:0]       dout_valid,
    output logic                      frame_done,
    output logic                      locked,
    output logic                      sync_err
);
    localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(CHANNELS - 1);

    typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [SW-1:0]             slot_q, slot_d;
    logic [CHANNELS*WIDTH-1:0] dout_q, dout_d;
    logic [CHANNELS-1:0]       dout_valid_q, dout_valid_d;
    logic                      frame_done_q, frame_done_d;
    logic                      sync_err_q, sync_err_d;
    logic                      locked_q, locked_d;

    logic                      wr_en;
    logic [SW-1:0]             wr_sel;

    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        wr_en        = 1'b0;
        wr_sel       = '0;

        if (din_valid) begin
            if (state_q == HUNT) begin
                if (sync) begin
                    wr_en   = 1'b1;
                    slot_d  = SW'(1);
                    state_d = LOCKED;
                end
            end else if (sync) begin
                // A sync anywhere but slot 0 abandons the partial frame and re-aligns.
                sync_err_d = (slot_q != '0);
                wr_en      = 1'b1;
                slot_d     = SW'(1);
            end else if (slot_q == '0) begin
                sync_err_d = 1'b1;
                slot_d     = '0;
                state_d    = HUNT;
            end else begin
                wr_en  = 1'b1;
                wr_sel = slot_q;
                if (slot_q == LAST_SLOT) begin
                    frame_done_d = 1'b1;
                    slot_d       = '0;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
        end

        dout_d       = dout_q;
        dout_valid_d = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (wr_en && (wr_sel == SW'(k))) begin
                dout_d[k*WIDTH +: WIDTH] = din;
                dout_valid_d[k]          = 1'b1;
            end
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
            locked_q     <= locked_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = locked_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb/tb_tdm_demux.sv - directed vector bench for tdm_demux with CHANNELS=4, WIDTH=8.
module tb_tdm_demux;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din;
    logic        din_valid;
    logic        sync;
    logic [31:0] dout;
    logic [3:0]  dout_valid;
    logic        frame_done;
    logic        locked;
    logic        sync_err;

    int checks   = 0;
    int failures = 0;

    tdm_demux #(.CHANNELS(4), .WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_done (frame_done),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        v;
        logic        s;
        logic [7:0]  din;
        logic [31:0] e_dout;
        logic [3:0]  e_dv;
        logic        e_fd;
        logic        e_se;
        logic        e_lk;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic r, input logic v, input logic s,
                       input logic [7:0] d, input logic [31:0] e_dout, input logic [3:0] e_dv,
                       input logic e_fd, input logic e_se, input logic e_lk);
        vec_t t;
        t.name = name; t.rst = r; t.v = v; t.s = s; t.din = d;
        t.e_dout = e_dout; t.e_dv = e_dv; t.e_fd = e_fd; t.e_se = e_se; t.e_lk = e_lk;
        vecs.push_back(t);
    endtask

    task automatic step(input string name, input logic r, input logic v, input logic s,
                        input logic [7:0] d, input logic [31:0] e_dout, input logic [3:0] e_dv,
                        input logic e_fd, input logic e_se, input logic e_lk);
        @(negedge clk);
        rst = r; din_valid = v; sync = s; din = d;
        @(posedge clk);
        #1;
        checks++;
        if (dout !== e_dout || dout_valid !== e_dv || frame_done !== e_fd ||
            sync_err !== e_se || locked !== e_lk) begin
            failures++;
            $display("FAIL %s: got dout=%h dv=%b fd=%b se=%b lk=%b, want dout=%h dv=%b fd=%b se=%b lk=%b",
                     name, dout, dout_valid, frame_done, sync_err, locked,
                     e_dout, e_dv, e_fd, e_se, e_lk);
        end
    endtask

    int fd_count;

    initial begin
        rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = 8'h00;

        add("reset0",      1, 0, 0, 8'h00, 32'h00000000, 4'b0000, 0, 0, 0);
        add("reset1",      1, 0, 0, 8'h00, 32'h00000000, 4'b0000, 0, 0, 0);
        add("hunt_drop11", 0, 1, 0, 8'h11, 32'h00000000, 4'b0000, 0, 0, 0);
        add("hunt_drop22", 0, 1, 0, 8'h22, 32'h00000000, 4'b0000, 0, 0, 0);
        add("lock_a0",     0, 1, 1, 8'hA0, 32'h000000A0, 4'b0001, 0, 0, 1);
        add("slot_a1",     0, 1, 0, 8'hA1, 32'h0000A1A0, 4'b0010, 0, 0, 1);
        add("slot_a2",     0, 1, 0, 8'hA2, 32'h00A2A1A0, 4'b0100, 0, 0, 1);
        add("slot_a3",     0, 1, 0, 8'hA3, 32'hA3A2A1A0, 4'b1000, 1, 0, 1);
        add("es_10",       0, 1, 1, 8'h10, 32'hA3A2A110, 4'b0001, 0, 0, 1);
        add("es_11",       0, 1, 0, 8'h11, 32'hA3A21110, 4'b0010, 0, 0, 1);
        add("es_20",       0, 1, 1, 8'h20, 32'hA3A21120, 4'b0001, 0, 1, 1);
        add("es_21",       0, 1, 0, 8'h21, 32'hA3A22120, 4'b0010, 0, 0, 1);
        add("es_22",       0, 1, 0, 8'h22, 32'hA3222120, 4'b0100, 0, 0, 1);
        add("es_23",       0, 1, 0, 8'h23, 32'h23222120, 4'b1000, 1, 0, 1);
        add("miss_55",     0, 1, 0, 8'h55, 32'h23222120, 4'b0000, 0, 1, 0);
        add("miss_idle",   0, 0, 1, 8'h77, 32'h23222120, 4'b0000, 0, 0, 0);
        add("relock_60",   0, 1, 1, 8'h60, 32'h23222160, 4'b0001, 0, 0, 1);
        add("relock_61",   0, 1, 0, 8'h61, 32'h23226160, 4'b0010, 0, 0, 1);
        add("mid_reset",   1, 1, 0, 8'h62, 32'h00000000, 4'b0000, 0, 0, 0);
        add("post_b0",     0, 1, 1, 8'hB0, 32'h000000B0, 4'b0001, 0, 0, 1);
        add("post_b1",     0, 1, 0, 8'hB1, 32'h0000B1B0, 4'b0010, 0, 0, 1);
        add("post_b2",     0, 1, 0, 8'hB2, 32'h00B2B1B0, 4'b0100, 0, 0, 1);
        add("post_b3",     0, 1, 0, 8'hB3, 32'hB3B2B1B0, 4'b1000, 1, 0, 1);

        foreach (vecs[i])
            step(vecs[i].name, vecs[i].rst, vecs[i].v, vecs[i].s, vecs[i].din,
                 vecs[i].e_dout, vecs[i].e_dv, vecs[i].e_fd, vecs[i].e_se, vecs[i].e_lk);

        // Gapped frame: idle cycles (with sync high but din_valid low) between slots 1 and 2.
        fd_count = 0;
        step("gap_c0", 0, 1, 1, 8'hC0, 32'hB3B2B1C0, 4'b0001, 0, 0, 1);
        fd_count += int'(frame_done);
        step("gap_c1", 0, 1, 0, 8'hC1, 32'hB3B2C1C0, 4'b0010, 0, 0, 1);
        fd_count += int'(frame_done);
        for (int g = 0; g < 3; g++) begin
            step("gap_idle", 0, 0, 1, 8'hEE, 32'hB3B2C1C0, 4'b0000, 0, 0, 1);
            fd_count += int'(frame_done);
        end
        step("gap_c2", 0, 1, 0, 8'hC2, 32'hB3C2C1C0, 4'b0100, 0, 0, 1);
        fd_count += int'(frame_done);
        step("gap_c3", 0, 1, 0, 8'hC3, 32'hC3C2C1C0, 4'b1000, 1, 0, 1);
        fd_count += int'(frame_done);
        step("gap_after", 0, 0, 0, 8'h00, 32'hC3C2C1C0, 4'b0000, 0, 0, 1);
        fd_count += int'(frame_done);

        checks++;
        if (fd_count != 1) begin
            failures++;
            $display("FAIL gap_frame_done_count: got %0d, want 1", fd_count);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive end of the team's time-division channel mux. A WIDTH-bit word stream carries CHANNELS interleaved slots. A sync flag marks slot 0.
- The block locks to the frame and steers each valid word into that channel's output register. It pulses a per-channel valid and a frame-complete flag.
- It detects framing errors, re-aligns on sync, and returns to hunting if sync is lost.
- Sits between the link/serial front end and per-channel consumers.

Parameters:
- CHANNELS, 4, number of TDM slots per frame; legal range 2..16.
- WIDTH, 8, bits per slot word.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  slot word.
- din_valid  input  1  din is valid this cycle.
- sync  input  1  qualifies din as slot 0; ignored when din_valid=0.
- dout  output  CHANNELS*WIDTH  channel registers; channel k occupies bits [k*WIDTH +: WIDTH].
- dout_valid  output  CHANNELS  one-cycle pulse: bit k is high the cycle after channel k is written.
- frame_done  output  1  one-cycle pulse the cycle after the last slot (CHANNELS-1) is written.
- locked  output  1  high while in the LOCKED state.
- sync_err  output  1  one-cycle pulse on a framing error.

Behaviour:
- Reset:
  - dout=0, dout_valid=0, frame_done=0, sync_err=0, locked=0.
  - State=HUNT, slot counter=0.
  - A reset asserted mid-frame aborts the frame. Registers already written are cleared.
- Slot counter:
  - Width is clog2(CHANNELS).
  - Wraps from CHANNELS-1 to 0. Non-power-of-2 CHANNELS must wrap explicitly, never by overflow.
- Latency: a word accepted at edge N is visible on dout, with its dout_valid bit high, after edge N. That gives one cycle of register latency.
- Cycles with din_valid=0: no state change. dout holds its value, and all pulses are low.
- HUNT state:
  - Valid words without sync are dropped and raise no error.
  - A valid word with sync is written to channel 0 and pulses dout_valid[0].
  - The slot counter then goes to 1 and the state goes to LOCKED.
- LOCKED state, valid word, sync=0, slot!=0:
  - Write the word to channel[slot] and pulse dout_valid[slot].
  - Advance the slot counter.
  - If slot==CHANNELS-1, also pulse frame_done and set the slot counter to 0.
- LOCKED state, valid word, sync=1, slot==0: normal frame start. Write channel 0 and set the slot counter to 1.
- LOCKED state, valid word, sync=1, slot!=0 (early sync):
  - Pulse sync_err. The partial frame is abandoned and frame_done is not pulsed.
  - Re-align: write the word to channel 0, pulse dout_valid[0], set the slot counter to 1, stay LOCKED.
- LOCKED state, valid word, sync=0, slot==0 (missing sync):
  - Pulse sync_err and drop the word.
  - Go to HUNT with the slot counter at 0. locked falls after this edge.
- Simultaneous events: frame_done and sync_err are never high in the same cycle. Exactly one dout_valid bit is high on any write cycle.
- Channels not written in a cycle hold their previous dout value, including across HUNT.
- locked is a registered copy of the state, so it is high the cycle after the sync word is accepted.

Test Plan:
- Reset then lock, CHANNELS=4, WIDTH=8:
  - Stimulus: rst high for 2 cycles, then valid words 0xA0 (sync=1), 0xA1, 0xA2, 0xA3.
  - Required response: dout=0xA3A2A1A0. dout_valid pulses 0001, 0010, 0100, 1000 on consecutive cycles. frame_done is high together with dout_valid[3]. locked=1 from the cycle after 0xA0.
- Hunt discard: words 0x11 and 0x22 with sync=0 before any sync -> dout stays 0, no pulses, sync_err=0, locked=0.
- Gapped stream: one frame with din_valid low for 3 cycles between slots 1 and 2 -> same final dout as back-to-back input; exactly one frame_done pulse; pulses low during the gaps.
- Early sync:
  - Stimulus: 0x10 (sync), 0x11, then 0x20 (sync), 0x21, 0x22, 0x23.
  - Required response: sync_err pulses once, on the 0x20 cycle. Channel 0 becomes 0x20, and frame_done fires once after 0x23.
- Missing sync: after a complete frame, a valid word 0x55 with sync=0 -> sync_err pulses, 0x55 is not written, locked=0 the next cycle, and the next sync word re-locks.
- Mid-frame reset: rst asserted after slot 1 of a frame -> all outputs 0 the next cycle and state HUNT. A following full frame 0xB0..0xB3 produces dout=0xB3B2B1B0 with one frame_done.
